// File: rtl/ctrl_event_pkg.sv
// Shared types and constants for the control-event queue.
// Latency: none (declarations and pure functions only).
// Backpressure: not applicable.
package ctrl_event_pkg;

  localparam int VEC_W  = 18;
  localparam int CODE_W = 5;

  // Bit positions of the decoder outputs inside the packed vector
  localparam int VEC_Z  = 0;
  localparam int VEC_A1 = 1;
  localparam int VEC_B1 = 2;
  localparam int VEC_C1 = 3;
  localparam int VEC_D1 = 4;
  localparam int VEC_E1 = 5;
  localparam int VEC_F1 = 6;
  localparam int VEC_G1 = 7;
  localparam int VEC_H1 = 8;
  localparam int VEC_I1 = 9;
  localparam int VEC_J1 = 10;
  localparam int VEC_K1 = 11;
  localparam int VEC_L1 = 12;
  localparam int VEC_M1 = 13;
  localparam int VEC_N1 = 14;
  localparam int VEC_O1 = 15;
  localparam int VEC_P1 = 16;
  localparam int VEC_Q1 = 17;

  typedef enum logic {IDLE, SCAN} state_e;

  // Index of the lowest set bit; 0 when the vector is empty
  function automatic logic [CODE_W-1:0] lowest_set(input logic [VEC_W-1:0] v);
    lowest_set = '0;
    for (int i = VEC_W - 1; i >= 0; i--) begin
      if (v[i]) lowest_set = CODE_W'(i);
    end
  endfunction

  // True when exactly one bit is set
  function automatic logic one_hot(input logic [VEC_W-1:0] v);
    one_hot = (v != '0) && ((v & (v - VEC_W'(1))) == '0);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Generic single-clock FIFO, DEPTH x W, first-word-fall-through read port.
// Latency: a push is visible on rdata/empty the cycle after the write edge.
// Backpressure: push ignored when full, pop ignored when empty; caller gates on full/empty.
module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry an extra wrap bit so full and empty differ only in the MSB
  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] mem_d [DEPTH];
  logic         do_push, do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q[AW-1:0]];

  // Next pointer and storage values
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (do_push) begin
      mem_d[wr_ptr_q[AW-1:0]] = wdata;
      wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + (AW+1)'(1);
  end

  // Pointer and storage registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/ctrl_event_queue.sv
// Buffers decoder vectors and emits each set bit as an indexed event, lowest index first.
// Latency: vector pushed into an empty queue yields its first event the cycle after the next edge.
// Backpressure: in_ready drops when the FIFO is full; events hold stable while ev_ready is low.
module ctrl_event_queue
  import ctrl_event_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [VEC_W-1:0]  in_vec,
  output logic              ev_valid,
  input  logic              ev_ready,
  output logic [CODE_W-1:0] ev_code,
  output logic              ev_last,
  output logic [CNT_W-1:0]  drop_cnt,
  output logic [CNT_W-1:0]  ev_cnt,
  output logic              busy
);

  logic              rdy_en_q, rdy_en_d;
  state_e            state_q, state_d;
  logic [VEC_W-1:0]  work_q, work_d;
  logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;
  logic [CNT_W-1:0]  ev_cnt_q, ev_cnt_d;
  logic              ev_valid_q, ev_valid_d;
  logic [CODE_W-1:0] ev_code_q, ev_code_d;
  logic              ev_last_q, ev_last_d;
  logic              fifo_full, fifo_empty, push, pop;
  logic [VEC_W-1:0]  head;

  // in_ready is held low through reset and rises one edge after release
  assign rdy_en_d = 1'b1;
  assign in_ready = rdy_en_q && !fifo_full;
  assign push     = in_valid && in_ready;
  assign pop      = (state_q == IDLE) && !fifo_empty;

  sync_fifo #(.DEPTH(DEPTH), .W(VEC_W)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (in_vec),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Scan FSM next state: load a head vector, then peel off one bit per accepted event
  always_comb begin
    state_d    = state_q;
    work_d     = work_q;
    drop_cnt_d = drop_cnt_q;
    ev_cnt_d   = ev_cnt_q;
    case (state_q)
      IDLE: begin
        if (pop) begin
          if (head != '0) begin
            work_d  = head;
            state_d = SCAN;
          end else if (drop_cnt_q != '1) begin
            drop_cnt_d = drop_cnt_q + CNT_W'(1);
          end
        end
      end
      SCAN: begin
        if (ev_ready) begin
          work_d = work_q & (work_q - VEC_W'(1));
          if (ev_cnt_q != '1) ev_cnt_d = ev_cnt_q + CNT_W'(1);
          if (ev_last_q) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    ev_valid_d = (state_d == SCAN);
    ev_code_d  = ev_valid_d ? lowest_set(work_d) : '0;
    ev_last_d  = ev_valid_d && one_hot(work_d);
  end

  // FSM state, working vector, counters and registered event outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdy_en_q   <= 1'b0;
      state_q    <= IDLE;
      work_q     <= '0;
      drop_cnt_q <= '0;
      ev_cnt_q   <= '0;
      ev_valid_q <= 1'b0;
      ev_code_q  <= '0;
      ev_last_q  <= 1'b0;
    end else begin
      rdy_en_q   <= rdy_en_d;
      state_q    <= state_d;
      work_q     <= work_d;
      drop_cnt_q <= drop_cnt_d;
      ev_cnt_q   <= ev_cnt_d;
      ev_valid_q <= ev_valid_d;
      ev_code_q  <= ev_code_d;
      ev_last_q  <= ev_last_d;
    end
  end

  assign ev_valid = ev_valid_q;
  assign ev_code  = ev_code_q;
  assign ev_last  = ev_last_q;
  assign drop_cnt = drop_cnt_q;
  assign ev_cnt   = ev_cnt_q;
  assign busy     = !fifo_empty || (state_q == SCAN);

endmodule
